// File: rtl/rv_p4_pkg.sv
// rv_p4_pkg: shared types and constants for the MAU hash key gather path
package rv_p4_pkg;
  typedef struct packed {
    logic       en;
    logic [9:0] off;
    logic [5:0] len;
  } hash_field_cfg_t;
  localparam int HASH_KEY_MAX_BYTES = 63;
  typedef enum logic [1:0] {HG_IDLE, HG_GATHER, HG_EMIT} hash_gather_st_e;
endpackage

// File: rtl/mau_hash_byte_extract.sv
// mau_hash_byte_extract: places one PHV byte field at key position acc_len, with byte enables and overrun flag
module mau_hash_byte_extract
  import rv_p4_pkg::*;
#(
  parameter int PHV_BYTES = 512
) (
  input  logic [PHV_BYTES*8-1:0]          phv,
  input  logic [9:0]                      off,
  input  logic [5:0]                      len,
  input  logic [5:0]                      acc_len,
  output logic [HASH_KEY_MAX_BYTES*8-1:0] slice,
  output logic [HASH_KEY_MAX_BYTES-1:0]   be,
  output logic                            overrun
);
  localparam int AW = $clog2(PHV_BYTES);
  genvar i;
  for (i = 0; i < HASH_KEY_MAX_BYTES; i++) begin : g_b
    logic [6:0]    k;
    logic [10:0]   src;
    logic [AW+2:0] bit_off;
    assign k       = 7'(i) - {1'b0, acc_len};
    assign src     = {1'b0, off} + {4'b0, k};
    assign bit_off = {src[AW-1:0], 3'b000};
    assign be[i]   = (6'(i) >= acc_len) && (k < {1'b0, len});
    // PHV bytes past the end read as zero but still occupy key space
    assign slice[i*8+:8] = (be[i] && src < 11'(PHV_BYTES)) ? phv[bit_off+:8] : 8'h00;
  end
  assign overrun = (len != 6'd0) && (({1'b0, off} + {5'b0, len}) > 11'(PHV_BYTES));
endmodule

// File: rtl/mau_hash_key_gather.sv
// mau_hash_key_gather: walks per-stage field descriptors over a PHV snapshot and packs a hash key
module mau_hash_key_gather
  import rv_p4_pkg::*;
#(
  parameter int PHV_BYTES  = 512,
  parameter int MAX_FIELDS = 8,
  parameter int TAG_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   phv_valid,
  output logic                                   phv_ready,
  input  logic [PHV_BYTES*8-1:0]                 phv_data,
  input  logic [TAG_W-1:0]                       phv_tag,
  input  hash_field_cfg_t [MAX_FIELDS-1:0]       cfg_field,
  output logic [511:0]                           hash_key,
  output logic [5:0]                             hash_key_len,
  output logic                                   hash_en,
  output logic [TAG_W-1:0]                       key_tag,
  output logic                                   key_trunc,
  output logic                                   key_cfg_err
);
  localparam int IW = MAX_FIELDS > 1 ? $clog2(MAX_FIELDS) : 1;
  localparam int KB = HASH_KEY_MAX_BYTES * 8;
  hash_gather_st_e                  state, nxt;
  logic [PHV_BYTES*8-1:0]           phv_q;
  logic [TAG_W-1:0]                 tag_q;
  hash_field_cfg_t [MAX_FIELDS-1:0] cfg_q;
  logic [IW-1:0]                    idx;
  logic [KB-1:0]                    acc_key, key_nx, slice;
  logic [HASH_KEY_MAX_BYTES-1:0]    be;
  logic [5:0]                       acc_len, len_nx;
  logic                             acc_trunc, acc_err, trunc_nx, err_nx;
  logic                             accept, last, use_f, overrun, clip;
  logic [6:0]                       sum;
  hash_field_cfg_t                  cur;
  assign accept = phv_valid && phv_ready;
  assign cur    = cfg_q[idx];
  assign last   = idx == IW'(MAX_FIELDS - 1);
  assign use_f  = cur.en && cur.len != 6'd0;
  mau_hash_byte_extract #(.PHV_BYTES(PHV_BYTES)) u_extract (
    .phv    (phv_q),
    .off    (cur.off),
    .len    (cur.len),
    .acc_len(acc_len),
    .slice  (slice),
    .be     (be),
    .overrun(overrun)
  );
  genvar i;
  for (i = 0; i < HASH_KEY_MAX_BYTES; i++) begin : g_k
    assign key_nx[i*8+:8] = (use_f && be[i]) ? slice[i*8+:8] : acc_key[i*8+:8];
  end
  // Clip keeps the length at 63 so it always fits the 6-bit count
  assign sum      = {1'b0, acc_len} + {1'b0, cur.len};
  assign clip     = use_f && sum > 7'(HASH_KEY_MAX_BYTES);
  assign len_nx   = use_f ? (clip ? 6'(HASH_KEY_MAX_BYTES) : sum[5:0]) : acc_len;
  assign trunc_nx = acc_trunc || clip;
  assign err_nx   = acc_err || (use_f && overrun);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HG_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == HG_GATHER ? (last ? HG_EMIT : HG_GATHER) : (accept ? HG_GATHER : HG_IDLE);
  always_comb begin
    phv_ready = rst_n && state != HG_GATHER;
    hash_en   = state == HG_EMIT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phv_q        <= '0;
      tag_q        <= '0;
      cfg_q        <= '0;
      idx          <= '0;
      acc_key      <= '0;
      acc_len      <= '0;
      acc_trunc    <= 1'b0;
      acc_err      <= 1'b0;
      hash_key     <= '0;
      hash_key_len <= '0;
      key_tag      <= '0;
      key_trunc    <= 1'b0;
      key_cfg_err  <= 1'b0;
    end else if (accept) begin
      phv_q     <= phv_data;
      tag_q     <= phv_tag;
      cfg_q     <= cfg_field;
      idx       <= '0;
      acc_key   <= '0;
      acc_len   <= '0;
      acc_trunc <= 1'b0;
      acc_err   <= 1'b0;
    end else if (state == HG_GATHER) begin
      idx       <= idx + 1'b1;
      acc_key   <= key_nx;
      acc_len   <= len_nx;
      acc_trunc <= trunc_nx;
      acc_err   <= err_nx;
      if (last) begin
        hash_key     <= {8'h00, key_nx};
        hash_key_len <= len_nx;
        key_tag      <= tag_q;
        key_trunc    <= trunc_nx;
        key_cfg_err  <= err_nx;
      end
    end
endmodule

// File: tb/tb_mau_hash_key_gather.sv
// tb_mau_hash_key_gather: random and directed stimulus checked every cycle against a byte-list key model
module tb_mau_hash_key_gather;
  import rv_p4_pkg::*;
  localparam int PB = 512, MF = 8, TW = 8;
  logic                        clk, rst_n, phv_valid, phv_ready, hash_en, key_trunc, key_cfg_err;
  logic [PB*8-1:0]             phv_data;
  logic [TW-1:0]               phv_tag, key_tag;
  hash_field_cfg_t [MF-1:0]    cfg_field;
  logic [511:0]                hash_key;
  logic [5:0]                  hash_key_len;
  typedef struct {
    int           due;
    logic [511:0] key;
    logic [5:0]   len;
    logic [7:0]   tag;
    logic         tr, er, lit, ltr, ler;
    logic [511:0] lkey;
    logic [5:0]   llen;
  } exp_t;
  exp_t         q[$];
  int           checks = 0, errors = 0, cyc = 0;
  logic         lit_pend, lit_tr, lit_er;
  logic [511:0] lit_key;
  logic [5:0]   lit_len;
  mau_hash_key_gather #(.PHV_BYTES(PB), .MAX_FIELDS(MF), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .phv_valid(phv_valid), .phv_ready(phv_ready),
    .phv_data(phv_data), .phv_tag(phv_tag), .cfg_field(cfg_field),
    .hash_key(hash_key), .hash_key_len(hash_key_len), .hash_en(hash_en),
    .key_tag(key_tag), .key_trunc(key_trunc), .key_cfg_err(key_cfg_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [PB*8-1:0] d, input hash_field_cfg_t [MF-1:0] c, input logic [7:0] t);
    exp_t e;
    int n = 0;
    e = '{due: 0, key: '0, len: '0, tag: t, tr: 0, er: 0, lit: 0, ltr: 0, ler: 0, lkey: '0, llen: '0};
    for (int f = 0; f < MF; f++)
      if (c[f].en && c[f].len != 0) begin
        if (int'(c[f].off) + int'(c[f].len) > PB) e.er = 1;
        for (int k = 0; k < int'(c[f].len); k++) begin
          int s = int'(c[f].off) + k;
          if (n < 63) begin
            e.key[n*8+:8] = s < PB ? d[s*8+:8] : 8'h00;
            n++;
          end else e.tr = 1;
        end
      end
    e.len = 6'(n);
    return e;
  endfunction
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask
  initial begin
    exp_t         e;
    logic [511:0] lk;
    logic [5:0]   ll;
    logic [7:0]   lt;
    logic         ltr, ler;
    lk = '0; ll = '0; lt = '0; ltr = 0; ler = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        lk = '0; ll = '0; lt = '0; ltr = 0; ler = 0;
        chk("rst_key", hash_key, '0);
        chk("rst_len", 512'(hash_key_len), '0);
        chk("rst_en", 512'(hash_en), '0);
        chk("rst_tag", 512'(key_tag), '0);
        chk("rst_flags", 512'({key_trunc, key_cfg_err}), '0);
        chk("rst_ready", 512'(phv_ready), '0);
      end else begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("hash_en", 512'(hash_en), 512'(1));
          chk("key", hash_key, e.key);
          chk("len", 512'(hash_key_len), 512'(e.len));
          chk("tag", 512'(key_tag), 512'(e.tag));
          chk("trunc", 512'(key_trunc), 512'(e.tr));
          chk("cfg_err", 512'(key_cfg_err), 512'(e.er));
          if (e.lit) begin
            chk("lit_key", hash_key, e.lkey);
            chk("lit_len", 512'(hash_key_len), 512'(e.llen));
            chk("lit_flags", 512'({key_trunc, key_cfg_err}), 512'({e.ltr, e.ler}));
          end
          lk = e.key; ll = e.len; lt = e.tag; ltr = e.tr; ler = e.er;
        end else begin
          chk("no_strobe", 512'(hash_en), '0);
          chk("hold_key", hash_key, lk);
          chk("hold_meta", 512'({hash_key_len, key_tag, key_trunc, key_cfg_err}), 512'({ll, lt, ltr, ler}));
        end
        chk("ready", 512'(phv_ready), 512'(q.size() == 0));
        if (phv_valid && phv_ready) begin
          e = model(phv_data, cfg_field, phv_tag);
          e.due = cyc + MF + 1;
          if (lit_pend) begin
            e.lit = 1; e.lkey = lit_key; e.llen = lit_len; e.ltr = lit_tr; e.ler = lit_er;
          end
          q.push_back(e);
        end
      end
    end
  end
  task automatic offer();
    int n = 0;
    phv_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (phv_ready) break;
      if (++n > 50) begin
        $display("FAIL accept_timeout: phv_ready never rose");
        $fatal(1);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    phv_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ramp();
    for (int j = 0; j < PB; j++) phv_data[j*8+:8] = 8'(j);
  endtask
  task automatic rand_phv();
    for (int w = 0; w < PB / 4; w++) phv_data[w*32+:32] = $urandom();
    phv_tag = 8'($urandom());
  endtask
  task automatic rand_cfg();
    for (int f = 0; f < MF; f++)
      cfg_field[f] = '{($urandom_range(0, 3) != 0), 10'($urandom_range(0, 530)), 6'($urandom_range(0, 24))};
  endtask
  task automatic directed(input logic [7:0] t, input logic [5:0] l, input logic tr, input logic er);
    phv_tag = t; lit_len = l; lit_tr = tr; lit_er = er; lit_pend = 1'b1;
    offer();
    lit_pend = 1'b0;
    idle(12);
  endtask
  initial begin
    rst_n = 1'b0; phv_valid = 1'b0; phv_data = '0; phv_tag = '0; cfg_field = '0;
    lit_pend = 1'b0; lit_key = '0; lit_len = '0; lit_tr = 0; lit_er = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    ramp();
    cfg_field = '0;
    cfg_field[0] = '{1'b1, 10'd4, 6'd4};
    lit_key = '0; lit_key[31:0] = 32'h07060504;
    directed(8'hA1, 6'd4, 0, 0);
    cfg_field = '0;
    cfg_field[0] = '{1'b1, 10'd10, 6'd2};
    cfg_field[1] = '{1'b0, 10'd50, 6'd5};
    cfg_field[2] = '{1'b1, 10'd20, 6'd0};
    cfg_field[3] = '{1'b1, 10'd0, 6'd3};
    lit_key = '0; lit_key[39:0] = 40'h020100_0B0A;
    directed(8'hA2, 6'd5, 0, 0);
    cfg_field = '0;
    for (int f = 0; f < 5; f++) cfg_field[f] = '{1'b1, 10'(f * 16), 6'd16};
    lit_key = '0;
    for (int b = 0; b < 63; b++) lit_key[b*8+:8] = 8'(b);
    directed(8'hA3, 6'd63, 1, 0);
    cfg_field = '0;
    cfg_field[0] = '{1'b1, 10'd510, 6'd4};
    lit_key = '0; lit_key[31:0] = 32'h0000FFFE;
    directed(8'hA4, 6'd4, 0, 1);
    for (int t = 1; t <= 3; t++) begin
      rand_phv();
      rand_cfg();
      phv_tag = 8'(t);
      offer();
      rand_cfg();
    end
    idle(12);
    ramp();
    cfg_field = '0;
    cfg_field[0] = '{1'b1, 10'd0, 6'd5};
    phv_tag = 8'h55;
    offer();
    phv_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_field[0] = '{1'b1, 10'd100, 6'd3};
    lit_key = '0; lit_key[23:0] = 24'h666564;
    directed(8'h66, 6'd3, 0, 0);
    for (int r = 0; r < 40; r++) begin
      rand_phv();
      rand_cfg();
      offer();
      if ($urandom_range(0, 1) != 0) idle($urandom_range(0, 3));
    end
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
